// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI link-side controller.
// RX CMD field positions and TX CMD encoding live here so the FSM and any checkers agree.
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_CMD  = 3'd1,
    ST_TX_DATA = 3'd2,
    ST_TX_STP  = 3'd3,
    ST_RX_TURN = 3'd4,
    ST_RX      = 3'd5,
    ST_TX_TURN = 3'd6
  } ulpi_state_t;

  localparam logic [3:0] ULPI_TXCMD_PREFIX = 4'b0100;
  localparam logic [1:0] RXEVENT_ACTIVE    = 2'b01;
  localparam int         RXCMD_EVENT_LSB   = 4;
  localparam int         RXCMD_EVENT_MSB   = 5;

  function automatic logic [1:0] rxcmd_event(input logic [7:0] cmd);
    return cmd[RXCMD_EVENT_MSB:RXCMD_EVENT_LSB];
  endfunction

  function automatic logic [7:0] txcmd_byte(input logic [3:0] pid);
    return {ULPI_TXCMD_PREFIX, pid};
  endfunction

endpackage

// File: rtl/ulpi_byte_counter.sv
// Saturating byte counter with clear, load, decrement and increment (priority in that order).
module ulpi_byte_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Counter register; saturates at both ends so a stray strobe never wraps.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ulpi_link_fsm.sv
// ULPI link-side controller: bus turnaround, RX CMD / RX data decode and
// streaming TX of programmable-length packets.
module ulpi_link_fsm
  import ulpi_pkg::*;
#(
  parameter int MAX_PKT_BYTES = 512,
  parameter int CNT_W         = $clog2(MAX_PKT_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             dir,
  input  logic             nxt,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             stp,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [CNT_W-1:0] tx_len,
  input  logic [7:0]       tx_byte,
  output logic             tx_pop,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_abort,
  output logic [7:0]       rx_byte,
  output logic             new_byte,
  output logic [7:0]       rx_cmd,
  output logic             rx_active,
  output logic             rx_done,
  output logic             rx_overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_PKT_BYTES);

  ulpi_state_t      state_r;
  ulpi_state_t      next_state_s;
  logic [3:0]       pid_r;
  logic             stp_r;
  logic             tx_busy_r;
  logic             tx_done_r;
  logic             tx_abort_r;
  logic [7:0]       rx_byte_r;
  logic             new_byte_r;
  logic [7:0]       rx_cmd_r;
  logic             rx_done_r;
  logic             rx_overflow_r;
  logic             rx_ended_r;

  logic             abort_s;
  logic             tx_load_s;
  logic [CNT_W-1:0] tx_len_clamped_s;
  logic             tx_pop_s;
  logic [7:0]       data_out_s;
  logic             rx_clr_s;
  logic             rx_inc_s;
  logic             rx_cmd_wr_s;
  logic             rx_active_s;
  logic             rx_done_s;
  logic [CNT_W-1:0] tx_rem_s;
  logic [CNT_W-1:0] rx_cnt_s;

  ulpi_byte_counter #(.CNT_W(CNT_W)) u_tx_rem (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (1'b0),
    .load     (tx_load_s),
    .load_val (tx_len_clamped_s),
    .dec      (tx_pop_s),
    .inc      (1'b0),
    .count    (tx_rem_s)
  );

  ulpi_byte_counter #(.CNT_W(CNT_W)) u_rx_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (rx_clr_s),
    .load     (1'b0),
    .load_val (CNT_ZERO),
    .dec      (1'b0),
    .inc      (rx_inc_s),
    .count    (rx_cnt_s)
  );

  // Next-state decode; dir always wins so the PHY never fights the link for the bus.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dir) begin
          next_state_s = ST_RX_TURN;
        end else if (tx_start) begin
          next_state_s = ST_TX_CMD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TX_CMD: begin
        if (dir) begin
          next_state_s = ST_RX_TURN;
          abort_s      = 1'b1;
        end else if (nxt) begin
          next_state_s = (tx_rem_s == CNT_ZERO) ? ST_TX_STP : ST_TX_DATA;
        end else begin
          next_state_s = ST_TX_CMD;
        end
      end
      ST_TX_DATA: begin
        if (dir) begin
          next_state_s = ST_RX_TURN;
          abort_s      = 1'b1;
        end else if (nxt && (tx_rem_s <= CNT_ONE)) begin
          next_state_s = ST_TX_STP;
        end else begin
          next_state_s = ST_TX_DATA;
        end
      end
      ST_TX_STP:  next_state_s = dir ? ST_RX_TURN : ST_IDLE;
      ST_RX_TURN: next_state_s = ST_RX;
      ST_RX:      next_state_s = dir ? ST_RX : ST_TX_TURN;
      ST_TX_TURN: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Datapath strobes and the link-driven bus value.
  always_comb begin
    tx_load_s        = (state_r == ST_IDLE) && !dir && tx_start;
    tx_len_clamped_s = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
    tx_pop_s         = (state_r == ST_TX_DATA) && nxt && !dir;
    rx_clr_s         = (next_state_s == ST_RX_TURN);
    rx_inc_s         = (state_r == ST_RX) && dir && nxt;
    rx_cmd_wr_s      = (state_r == ST_RX) && dir && !nxt;
    rx_active_s      = (rxcmd_event(rx_cmd_r) == RXEVENT_ACTIVE);
    if (dir) begin
      data_out_s = 8'h00;
    end else begin
      case (state_r)
        ST_TX_CMD:  data_out_s = txcmd_byte(pid_r);
        ST_TX_DATA: data_out_s = tx_byte;
        default:    data_out_s = 8'h00;
      endcase
    end
  end

  // End of packet: RxActive drops, or the PHY releases the bus mid-packet; once per packet.
  always_comb begin
    if ((state_r == ST_RX) && !rx_ended_r) begin
      rx_done_s = (rx_cmd_wr_s && rx_active_s && (rxcmd_event(data_in) != RXEVENT_ACTIVE)) ||
                  (!dir && (rx_cnt_s != CNT_ZERO));
    end else begin
      rx_done_s = 1'b0;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      pid_r         <= 4'h0;
      stp_r         <= 1'b0;
      tx_busy_r     <= 1'b0;
      tx_done_r     <= 1'b0;
      tx_abort_r    <= 1'b0;
      rx_byte_r     <= 8'h00;
      new_byte_r    <= 1'b0;
      rx_cmd_r      <= 8'h00;
      rx_done_r     <= 1'b0;
      rx_overflow_r <= 1'b0;
      rx_ended_r    <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pid_r      <= tx_load_s ? tx_pid : pid_r;
      stp_r      <= (next_state_s == ST_TX_STP);
      tx_done_r  <= (next_state_s == ST_TX_STP);
      tx_abort_r <= abort_s;
      tx_busy_r  <= (next_state_s == ST_TX_CMD) || (next_state_s == ST_TX_DATA) ||
                    (next_state_s == ST_TX_STP) || abort_s;
      new_byte_r <= rx_inc_s;
      rx_byte_r  <= rx_inc_s ? data_in : rx_byte_r;
      rx_cmd_r   <= rx_cmd_wr_s ? data_in : rx_cmd_r;
      rx_done_r  <= rx_done_s;
      if (rx_clr_s) begin
        rx_ended_r <= 1'b0;
      end else if (rx_done_s) begin
        rx_ended_r <= 1'b1;
      end else if (rx_cmd_wr_s && (rxcmd_event(data_in) == RXEVENT_ACTIVE)) begin
        rx_ended_r <= 1'b0;
      end else begin
        rx_ended_r <= rx_ended_r;
      end
      // Count at MAX_LEN before this byte means this byte is one too many.
      if (rx_clr_s) begin
        rx_overflow_r <= 1'b0;
      end else if (rx_inc_s && (rx_cnt_s >= MAX_LEN)) begin
        rx_overflow_r <= 1'b1;
      end else begin
        rx_overflow_r <= rx_overflow_r;
      end
    end
  end

  assign data_out    = data_out_s;
  assign stp         = stp_r;
  assign tx_pop      = tx_pop_s;
  assign tx_busy     = tx_busy_r;
  assign tx_done     = tx_done_r;
  assign tx_abort    = tx_abort_r;
  assign rx_byte     = rx_byte_r;
  assign new_byte    = new_byte_r;
  assign rx_cmd      = rx_cmd_r;
  assign rx_active   = rx_active_s;
  assign rx_done     = rx_done_r;
  assign rx_overflow = rx_overflow_r;

endmodule

// File: tb/tb_ulpi_link_fsm.sv
// Directed bench for ulpi_link_fsm with MAX_PKT_BYTES=4 (3-bit counters).
module tb_ulpi_link_fsm;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       dir;
  logic       nxt;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       stp;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [2:0] tx_len;
  logic [7:0] tx_byte;
  logic       tx_pop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_abort;
  logic [7:0] rx_byte;
  logic       new_byte;
  logic [7:0] rx_cmd;
  logic       rx_active;
  logic       rx_done;
  logic       rx_overflow;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  ulpi_link_fsm #(.MAX_PKT_BYTES(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dir         (dir),
    .nxt         (nxt),
    .data_in     (data_in),
    .data_out    (data_out),
    .stp         (stp),
    .tx_start    (tx_start),
    .tx_pid      (tx_pid),
    .tx_len      (tx_len),
    .tx_byte     (tx_byte),
    .tx_pop      (tx_pop),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_abort    (tx_abort),
    .rx_byte     (rx_byte),
    .new_byte    (new_byte),
    .rx_cmd      (rx_cmd),
    .rx_active   (rx_active),
    .rx_done     (rx_done),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst = 1'b0; dir = 1'b0; nxt = 1'b0; data_in = 8'h00;
    tx_start = 1'b0; tx_pid = 4'h0; tx_len = 3'd0; tx_byte = 8'h00;
    tick(); tick();
    chk("rst_flags", 32'({stp, tx_pop, tx_busy, tx_done, tx_abort, new_byte, rx_active, rx_done, rx_overflow}), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_rx_cmd", 32'(rx_cmd), 32'h00);
    n_rst = 1'b1;

    // RX CMD only: turnaround cycles ignore data_in, then FF lands in rx_cmd
    dir = 1'b1; data_in = 8'hFF;
    tick();
    chk("rxc_dout_dir", 32'(data_out), 32'h00);
    tick();
    chk("rxc_turn_ignored", 32'(rx_cmd), 32'h00);
    tick();
    chk("rxc_cmd", 32'(rx_cmd), 32'hFF);
    chk("rxc_no_newbyte", 32'(new_byte), 32'h0);
    chk("rxc_not_active", 32'(rx_active), 32'h0);
    tick();
    chk("rxc_no_newbyte2", 32'(new_byte), 32'h0);
    dir = 1'b0;
    tick();
    chk("rxc_no_done", 32'(rx_done), 32'h0);
    tick();

    // RX packet: CMD 10, data FF, AA, CMD 00
    dir = 1'b1; data_in = 8'h10;
    tick(); tick(); tick();
    chk("rxp_cmd", 32'(rx_cmd), 32'h10);
    chk("rxp_active", 32'(rx_active), 32'h1);
    nxt = 1'b1; data_in = 8'hFF;
    tick();
    chk("rxp_b0", 32'({new_byte, rx_byte}), 32'h1FF);
    data_in = 8'hAA;
    tick();
    chk("rxp_b1", 32'({new_byte, rx_byte}), 32'h1AA);
    nxt = 1'b0; data_in = 8'h00;
    tick();
    chk("rxp_nb_end", 32'(new_byte), 32'h0);
    chk("rxp_done", 32'(rx_done), 32'h1);
    chk("rxp_inactive", 32'(rx_active), 32'h0);
    tick();
    chk("rxp_done_once", 32'(rx_done), 32'h0);
    dir = 1'b0;
    tick();
    chk("rxp_no_done_dir", 32'(rx_done), 32'h0);
    chk("rxp_no_ovf", 32'(rx_overflow), 32'h0);
    tick();

    // TX packet pid=3 len=3, PHY delays nxt by 2 cycles
    tx_start = 1'b1; tx_pid = 4'h3; tx_len = 3'd3; tx_byte = 8'hB0;
    #1;
    chk("tx_idle_busy", 32'(tx_busy), 32'h0);
    tick();
    tx_start = 1'b0; tx_pid = 4'h0; tx_len = 3'd0;
    #1;
    chk("tx_cmd_byte", 32'(data_out), 32'h43);
    chk("tx_busy", 32'(tx_busy), 32'h1);
    chk("tx_cmd_nopop", 32'(tx_pop), 32'h0);
    tick(); tick();
    chk("tx_cmd_hold", 32'(data_out), 32'h43);
    nxt = 1'b1;
    #1;
    chk("tx_cmd_nopop_nxt", 32'(tx_pop), 32'h0);
    tick();
    chk("tx_d0", 32'({tx_pop, data_out}), 32'h1B0);
    tick();
    tx_byte = 8'hB1;
    #1;
    chk("tx_d1", 32'({tx_pop, data_out}), 32'h1B1);
    tick();
    tx_byte = 8'hB2; nxt = 1'b0;
    #1;
    chk("tx_d2_wait", 32'({tx_pop, data_out}), 32'h0B2);
    tick();
    chk("tx_d2_held", 32'({stp, data_out}), 32'h0B2);
    nxt = 1'b1;
    #1;
    chk("tx_d2", 32'({tx_pop, data_out}), 32'h1B2);
    tick();
    nxt = 1'b0;
    #1;
    chk("tx_stp", 32'({stp, tx_done, tx_busy, tx_pop}), 32'hE);
    chk("tx_stp_dout", 32'(data_out), 32'h00);
    tick();
    chk("tx_idle_after", 32'({stp, tx_done, tx_busy}), 32'h0);

    // Abort during the 2nd data byte
    tx_start = 1'b1; tx_pid = 4'hA; tx_len = 3'd3; tx_byte = 8'hC0;
    tick();
    tx_start = 1'b0; nxt = 1'b1;
    tick();
    tick();
    tx_byte = 8'hC1; nxt = 1'b0; dir = 1'b1;
    #1;
    chk("ab_dout_dir", 32'({tx_pop, data_out}), 32'h000);
    tick();
    chk("ab_pulse", 32'({tx_abort, tx_busy, stp, tx_done}), 32'hC);
    tick();
    chk("ab_clear", 32'({tx_abort, tx_busy, stp}), 32'h0);
    dir = 1'b0;
    tick(); tick();

    // Overflow: 5 data bytes into a 4-byte limit
    dir = 1'b1; data_in = 8'h10;
    tick(); tick(); tick();
    nxt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = 8'(i);
      tick();
    end
    chk("ovf_at_max", 32'(rx_overflow), 32'h0);
    data_in = 8'h05;
    tick();
    chk("ovf_set", 32'(rx_overflow), 32'h1);
    chk("ovf_fwd", 32'({new_byte, rx_byte}), 32'h105);
    nxt = 1'b0; data_in = 8'h00;
    tick();
    dir = 1'b0;
    tick(); tick();
    chk("ovf_sticky", 32'(rx_overflow), 32'h1);
    dir = 1'b1;
    tick();
    chk("ovf_cleared", 32'(rx_overflow), 32'h0);
    dir = 1'b0;
    tick(); tick(); tick();

    // dir beats a simultaneous tx_start
    dir = 1'b1; tx_start = 1'b1; tx_len = 3'd1;
    tick();
    tx_start = 1'b0; dir = 1'b0;
    chk("prio_no_busy", 32'(tx_busy), 32'h0);
    tick(); tick(); tick();
    chk("prio_no_stp", 32'({stp, tx_busy}), 32'h0);

    // Length 7 clamps to 4 payload bytes
    tx_start = 1'b1; tx_pid = 4'h1; tx_len = 3'd7; nxt = 1'b1;
    tick();
    tx_start = 1'b0;
    tick();
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (stp) break;
      if (tx_pop) pops++;
      tick();
    end
    chk("clamp_pops", 32'(pops), 32'd4);
    chk("clamp_stp", 32'(stp), 32'h1);
    tick();

    // PID-only packet
    tx_start = 1'b1; tx_pid = 4'h5; tx_len = 3'd0;
    tick();
    tx_start = 1'b0;
    #1;
    chk("pid0_cmd", 32'({tx_pop, data_out}), 32'h045);
    tick();
    chk("pid0_stp", 32'({stp, tx_done, tx_pop}), 32'h6);
    nxt = 1'b0;
    tick();

    // Reset mid-packet: IDLE next edge, no stp
    tx_start = 1'b1; tx_pid = 4'h2; tx_len = 3'd3; tx_byte = 8'h77; nxt = 1'b1;
    tick();
    tx_start = 1'b0;
    tick();
    n_rst = 1'b0;
    tick();
    chk("mrst_flags", 32'({stp, tx_busy, tx_done, tx_pop}), 32'h0);
    chk("mrst_dout", 32'(data_out), 32'h00);
    chk("mrst_rx_byte", 32'(rx_byte), 32'h00);
    n_rst = 1'b1; nxt = 1'b0;
    tick();
    chk("mrst_idle", 32'({stp, tx_busy, data_out}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
